// File: rtl/exp_pkg.sv
// Shared types and sizing for the BF16 exp segment-table loader.
// Entry widths come from BASE_WIDTH / OFFSET_WIDTH (16 bits when not supplied by the build).
`ifndef BASE_WIDTH
`define BASE_WIDTH 16
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 16
`endif

package exp_pkg;
    localparam int BASE_W    = `BASE_WIDTH;
    localparam int OFF_W     = `OFFSET_WIDTH;
    localparam int NUM_IDX   = 13;
    localparam int NUM_SGN   = 2;
    localparam int ENTRY_CNT = NUM_SGN * NUM_IDX;
    localparam int CKSUM_W   = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/exp_entry_counter.sv
// Walks the table entries sgn=0 idx 0..12, then sgn=1 idx 0..12, and flags the last entry.
module exp_entry_counter
    import exp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic             sgn,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_IDX - 1);

    logic             sgn_reg;
    logic [IDX_W-1:0] idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_reg <= 1'b0;
            idx_reg <= '0;
        end else if (clr) begin
            sgn_reg <= 1'b0;
            idx_reg <= '0;
        end else if (inc) begin
            if (idx_reg == IDX_MAX) begin
                idx_reg <= '0;
                sgn_reg <= ~sgn_reg;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign sgn  = sgn_reg;
    assign idx  = idx_reg;
    assign last = sgn_reg && (idx_reg == IDX_MAX);
endmodule

// File: rtl/exp_table_loader.sv
// Loads the exp MAC segment table from a valid/ready word stream, one cfg write per accept.
// Optional trailing checksum word enabled by EXP_LOADER_CHECKSUM_EN.
module exp_table_loader
    import exp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BASE_W-1:0] in_base,
    input  logic [OFF_W-1:0]  in_offset,
    output logic              cfg_w_en,
    output logic              cfg_sgn,
    output logic [IDX_W-1:0]  cfg_idx,
    output logic [BASE_W-1:0] cfg_base,
    output logic [OFF_W-1:0]  cfg_offset,
    output logic              busy,
    output logic              table_valid,
    output logic              err
);
    state_t             state_reg, state_next;
    logic               accept, wr;
    logic               cnt_sgn, cnt_last;
    logic [IDX_W-1:0]   cnt_idx;

    logic               w_en_reg;
    logic               sgn_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [BASE_W-1:0]  base_reg;
    logic [OFF_W-1:0]   offset_reg;

    assign in_ready = (state_reg == LOAD) || (state_reg == CHECK);
    assign accept   = in_valid && in_ready;
    // A word arriving alongside start is dropped: the restart wins.
    assign wr       = accept && (state_reg == LOAD) && !start;

    exp_entry_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (wr),
        .sgn  (cnt_sgn),
        .idx  (cnt_idx),
        .last (cnt_last)
    );

`ifdef EXP_LOADER_CHECKSUM_EN
    logic [CKSUM_W-1:0] sum_reg;
    logic               err_reg;
    logic               ck_match;

    assign ck_match = (CKSUM_W'(in_base) == sum_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (start)
                sum_reg <= '0;
            else if (wr)
                sum_reg <= sum_reg + CKSUM_W'(in_base) + CKSUM_W'(in_offset);

            if (start)
                err_reg <= 1'b0;
            else if (state_reg == CHECK && in_valid && !ck_match)
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (start)
                    state_next = LOAD;
                else if (wr && cnt_last)
`ifdef EXP_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
            end
`ifdef EXP_LOADER_CHECKSUM_EN
            CHECK: begin
                if (start)
                    state_next = LOAD;
                else if (in_valid)
                    state_next = ck_match ? DONE : IDLE;
            end
`endif
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_reg   <= 1'b0;
            sgn_reg    <= 1'b0;
            idx_reg    <= '0;
            base_reg   <= '0;
            offset_reg <= '0;
        end else begin
            w_en_reg <= wr;
            if (wr) begin
                sgn_reg    <= cnt_sgn;
                idx_reg    <= cnt_idx;
                base_reg   <= in_base;
                offset_reg <= in_offset;
            end
        end
    end

    assign cfg_w_en    = w_en_reg;
    assign cfg_sgn     = sgn_reg;
    assign cfg_idx     = idx_reg;
    assign cfg_base    = base_reg;
    assign cfg_offset  = offset_reg;
    assign busy        = in_ready;
    assign table_valid = (state_reg == DONE);
endmodule
